// File: rtl/bcd_counter_pkg.sv
// bcd_counter_pkg: shared BCD digit type, limits and helpers for bcd_counter_n.
package bcd_counter_pkg;
  typedef logic [3:0] bcd_digit_t;
  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;
  function automatic bcd_digit_t bcd_sat(bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction
  function automatic logic [63:0] pow10(int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one decimal digit with clear, saturating load and up/down step.
module bcd_digit
  import bcd_counter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  bcd_digit_t load_digit,
  input  logic       en,
  input  logic       dir,
  output bcd_digit_t q,
  output logic       at_max,
  output logic       at_min
);
  assign at_max = q == BCD_MAX;
  assign at_min = q == BCD_MIN;
  always_ff @(posedge clk)
    if (reset || clear) q <= BCD_MIN;
    else if (load) q <= bcd_sat(load_digit);
    else if (en) q <= dir ? (at_min ? BCD_MAX : q - 4'd1) : (at_max ? BCD_MIN : q + 4'd1);
endmodule

// File: rtl/bcd_counter_n.sv
// bcd_counter_n: N-digit up/down BCD counter with load, wrap flags and binary mirror.
// Define BCD_COUNTER_SATURATE_EN to hold the count at its limits instead of wrapping.
module bcd_counter_n
  import bcd_counter_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_WIDTH  = 14
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    step,
  input  logic                    dir,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [BIN_WIDTH-1:0]    bin_out,
  output logic                    wrap,
  output logic                    wrap_sticky
);
  if ((64'd1 << BIN_WIDTH) < pow10(NUM_DIGITS)) begin : g_width_check
    $error("BIN_WIDTH too small for NUM_DIGITS");
  end
  logic                  step_q, step_evt, wrap_evt, hold;
  logic [NUM_DIGITS-1:0] at_max, at_min, en;
  logic [NUM_DIGITS:0]   cy, bw;
  logic [BIN_WIDTH-1:0]  bin_next;
  // step_q follows step even in reset so a step held across reset is not counted
  always_ff @(posedge clk) step_q <= step;
  assign step_evt = step & ~step_q;
  assign cy[0] = 1'b1;
  assign bw[0] = 1'b1;
  assign wrap_evt = step_evt & (dir ? bw[NUM_DIGITS] : cy[NUM_DIGITS]);
`ifdef BCD_COUNTER_SATURATE_EN
  assign hold = wrap_evt;
`else
  assign hold = 1'b0;
`endif
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    assign cy[d+1] = cy[d] & at_max[d];
    assign bw[d+1] = bw[d] & at_min[d];
    assign en[d]   = step_evt & ~hold & (dir ? bw[d] : cy[d]);
    bcd_digit u_digit (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .load      (load),
      .load_digit(load_value[4*d +: 4]),
      .en        (en[d]),
      .dir       (dir),
      .q         (bcd_out[4*d +: 4]),
      .at_max    (at_max[d]),
      .at_min    (at_min[d])
    );
  end
  always_comb begin
    bin_next = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      bin_next = bin_next + BIN_WIDTH'(64'(bcd_out[4*i +: 4]) * pow10(i));
  end
  always_ff @(posedge clk) begin
    bin_out     <= reset ? '0 : bin_next;
    wrap        <= !(reset || clear || load) && wrap_evt;
    wrap_sticky <= (reset || clear) ? 1'b0 : (wrap_sticky || (!load && wrap_evt));
  end
endmodule

// File: tb/tb_bcd_counter_n.sv
// tb_bcd_counter_n: random and directed checks of bcd_counter_n against an integer-count model.
module tb_bcd_counter_n;
  localparam int ND = 4;
  localparam int BW = 14;
  localparam int MAXV = 9999;
  logic clk = 0, reset = 1, step = 0, dir = 0, clear = 0, load = 0;
  logic [4*ND-1:0] load_value = '0, bcd_out;
  logic [BW-1:0] bin_out;
  logic wrap, wrap_sticky;
  int checks = 0, errors = 0;
  int m_cnt = 0, m_bin = 0;
  bit m_wrap = 0, m_sticky = 0, m_prev = 0, sat = 0;

  bcd_counter_n #(.NUM_DIGITS(ND), .BIN_WIDTH(BW)) dut (
    .clk(clk), .reset(reset), .step(step), .dir(dir), .clear(clear), .load(load),
    .load_value(load_value), .bcd_out(bcd_out), .bin_out(bin_out), .wrap(wrap),
    .wrap_sticky(wrap_sticky)
  );

  always #5 clk = ~clk;

  function automatic logic [4*ND-1:0] to_bcd(int v);
    logic [4*ND-1:0] r;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd_sat(logic [4*ND-1:0] b);
    int v = 0, w = 1;
    for (int i = 0; i < ND; i++) begin
      v += ((b[4*i +: 4] > 4'd9) ? 9 : int'(b[4*i +: 4])) * w;
      w *= 10;
    end
    return v;
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model(input bit r, input bit s, input bit d, input bit c, input bit l,
                       input logic [4*ND-1:0] lv);
    bit evt;
    evt = s && !m_prev;
    m_prev = s;
    m_bin = r ? 0 : m_cnt;
    m_wrap = 0;
    if (r || c) begin
      m_cnt = 0;
      m_sticky = 0;
    end else if (l) m_cnt = from_bcd_sat(lv);
    else if (evt) begin
      if ((!d && m_cnt == MAXV) || (d && m_cnt == 0)) begin
        m_wrap = 1;
        m_sticky = 1;
        if (!sat) m_cnt = d ? MAXV : 0;
      end else m_cnt = d ? m_cnt - 1 : m_cnt + 1;
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit d, input bit c, input bit l,
                     input logic [4*ND-1:0] lv);
    @(negedge clk);
    reset = r; step = s; dir = d; clear = c; load = l; load_value = lv;
    model(r, s, d, c, l, lv);
    @(posedge clk);
    #1;
    chk("bcd_out", 64'(bcd_out), 64'(to_bcd(m_cnt)));
    chk("bin_out", 64'(bin_out), 64'(m_bin));
    chk("wrap", 64'(wrap), 64'(m_wrap));
    chk("wrap_sticky", 64'(wrap_sticky), 64'(m_sticky));
  endtask

  task automatic pulse(input bit d);
    cyc(0, 1, d, 0, 0, '0);
    cyc(0, 0, d, 0, 0, '0);
  endtask

  initial begin
`ifdef BCD_COUNTER_SATURATE_EN
    sat = 1;
`endif
    cyc(1, 0, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, 0, '0);
    chk("reset_bcd", 64'(bcd_out), 64'h0);
    chk("reset_wrap", 64'({wrap, wrap_sticky}), 64'h0);
    for (int i = 0; i < 12; i++) pulse(0);
    chk("count12_bcd", 64'(bcd_out), 64'h0012);
    chk("count12_bin", 64'(bin_out), 64'd12);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, '0);
    chk("held_step_once", 64'(bcd_out), 64'h0013);
    cyc(0, 0, 0, 0, 1, 16'h9998);
    pulse(0);
    chk("up_to_9999", 64'(bcd_out), 64'h9999);
    cyc(0, 1, 0, 0, 0, '0);
    chk("up_wrap_bcd", 64'(bcd_out), sat ? 64'h9999 : 64'h0000);
    chk("up_wrap_pulse", 64'(wrap), 64'h1);
    cyc(0, 0, 0, 0, 0, '0);
    chk("wrap_one_cycle", 64'({wrap, wrap_sticky}), 64'h1);
    cyc(0, 0, 0, 1, 0, '0);
    cyc(0, 1, 1, 0, 0, '0);
    chk("down_wrap_bcd", 64'(bcd_out), sat ? 64'h0000 : 64'h9999);
    chk("down_wrap_pulse", 64'(wrap), 64'h1);
    cyc(0, 0, 1, 0, 0, '0);
    chk("down_wrap_bin", 64'(bin_out), sat ? 64'd0 : 64'd9999);
    cyc(0, 0, 0, 0, 1, 16'h1000);
    pulse(1);
    chk("borrow", 64'(bcd_out), 64'h0999);
    cyc(0, 0, 0, 0, 1, 16'h0099);
    pulse(0);
    chk("carry", 64'(bcd_out), 64'h0100);
    cyc(0, 0, 0, 0, 1, 16'h3AF7);
    chk("load_clamp", 64'(bcd_out), 64'h3997);
    cyc(0, 1, 0, 0, 1, 16'h0005);
    chk("load_beats_step", 64'(bcd_out), 64'h0005);
    cyc(0, 0, 0, 1, 1, 16'h1234);
    chk("clear_beats_load", 64'({bcd_out, wrap_sticky}), 64'h0);
    cyc(0, 0, 0, 0, 1, 16'h0999);
    cyc(0, 1, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, 0, '0);
    chk("reset_mid", 64'({bcd_out, bin_out, wrap, wrap_sticky}), 64'h0);
    cyc(0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 4000; i++) begin
      logic [4*ND-1:0] lv;
      int k;
      k = int'($urandom_range(0, 4));
      lv = (k == 0) ? 16'h9999 : (k == 1) ? 16'h0000 : (k == 2) ? 16'h9998 :
           (k == 3) ? 16'h0001 : 16'($urandom);
      cyc($urandom_range(0, 199) == 0, 1'($urandom), 1'($urandom),
          $urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0, lv);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
